hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Control side of the pipeline stage registers: generates PC/IF_ID write enables, ID_EX
//  bubble, per-stage flushes and a global hold from ID/EX and EX/MEM fields.
//  - Load-use hazards stall for a configurable number of cycles.
//  - Taken branches, resolved in MEM, flush the three younger stages.
//  - A data-memory busy signal freezes the whole pipeline, guarded by a watchdog.
// PARAMETERS
//  LOAD_USE_STALLS  1       stall cycles per load-use hazard (legal 1..3)
//  MEM_TIMEOUT      16'd64  MemBusy cycles tolerated before MemTimeout sets (>=1)
// PORTS
//  CLK               in   1   clock, rising edge
//  RST_N             in   1   asynchronous active-low reset
//  IF_ID_RegisterRs  in   5   rs of instruction in ID
//  IF_ID_RegisterRt  in   5   rt of instruction in ID
//  IF_ID_UsesRt      in   1   ID instruction reads rt as a source
//  ID_EX_MemRead     in   1   instruction in EX is a load
//  ID_EX_RegisterRt  in   5   load destination in EX
//  BranchTaken       in   1   branch in MEM resolved taken (Branch_OUT & ZERO_OUT)
//  MemBusy           in   1   data memory not ready for instruction in MEM
//  PCWrite           out  1   PC load enable
//  IF_ID_Write       out  1   IF/ID load enable
//  ID_EX_Bubble      out  1   zero ID/EX control fields on next edge
//  IF_ID_Flush       out  1   clear IF/ID to nop
//  ID_EX_Flush       out  1   clear ID/EX control fields
//  EX_MEM_Flush      out  1   clear EX/MEM control fields
//  PipeHold          out  1   hold ID/EX, EX/MEM, MEM/WB contents
//  MemTimeout        out  1   sticky watchdog flag
// BEHAVIOUR
//  - Reset (RST_N=0, async):
//    - state=RUN, stall counter=0, watchdog=0, MemTimeout=0.
//    - While RST_N=0: PCWrite=0, IF_ID_Write=0, PipeHold=0; Bubble and all three Flush=1.
//  - Outputs are Mealy: combinational from state + inputs, effective the same cycle.
//    - Default: PCWrite=1, IF_ID_Write=1, all others 0.
//  - Hazard: ID_EX_MemRead & ID_EX_RegisterRt!=0 &
//    (Rt==IF_ID_RegisterRs | (IF_ID_UsesRt & Rt==IF_ID_RegisterRt)).
//  - Priority per cycle: MemBusy > BranchTaken > load-use stall.
//  - States:
//    - RUN:
//      - MemBusy -> PipeHold=1, PCWrite=0, IF_ID_Write=0; stay RUN.
//      - else BranchTaken -> all three Flush=1, PCWrite=1; stay RUN.
//      - else hazard -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1;
//        if LOAD_USE_STALLS>1: cnt<=LOAD_USE_STALLS-1, go LDSTALL.
//    - LDSTALL: same stall outputs as a hazard cycle (hazard term ignored).
//      - cnt decrements; at cnt==1 the next state is RUN.
//      - MemBusy: hold outputs as in RUN, cnt frozen.
//      - BranchTaken: flush as in RUN, cnt<=0, next RUN (abort stall).
//  - Total stall length per hazard = LOAD_USE_STALLS cycles exactly, excluding MemBusy cycles.
//  - Watchdog: 16-bit counter.
//    - Increments each cycle MemBusy=1; clears when MemBusy=0.
//    - Saturates at MEM_TIMEOUT.
//    - MemTimeout<=1 on the edge where it reaches MEM_TIMEOUT; stays 1 until reset.
//  - Counter widths: cnt is 2 bits; no wrap in any legal config.
// CONFIGURATION
//  HAZARD_PERF_EN defined: extra out ports StallCount[31:0], FlushCount[31:0].
//    - Reset 0; wrap mod 2^32.
//    - StallCount +1 per cycle with ID_EX_Bubble=1 (reset excluded).
//    - FlushCount +1 per cycle with BranchTaken flush.
//  HAZARD_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. RST_N=0 mid-LDSTALL -> PCWrite=0, all Flush=1 at once;
//     RST_N=1 with idle inputs -> PCWrite=1, IF_ID_Write=1 next cycle.
//  2. LOAD_USE_STALLS=2, MemRead=1, ID_EX Rt=8, IF_ID Rs=8 ->
//     PCWrite=0, ID_EX_Bubble=1 for exactly 2 cycles, then 1.
//  3. Same with ID_EX Rt=0, or Rt=8 vs IF_ID Rt=8 with UsesRt=0 -> no stall.
//  4. BranchTaken=1 in first LDSTALL cycle -> all Flush=1, PCWrite=1 that cycle; RUN next.
//  5. MEM_TIMEOUT=2, MemBusy=1 for 3 cycles -> PipeHold=1 for 3 cycles;
//     MemTimeout=1 after the 2nd busy edge, stays 1 after MemBusy=0.
//  6. HAZARD_PERF_EN, scenario 2 then one taken branch -> StallCount=2, FlushCount=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: load-use stall, branch flush, memory-busy hold
// Optional HAZARD_PERF_EN adds StallCount/FlushCount performance counters.
module hazard_ctrl #(
  parameter int          LOAD_USE_STALLS = 1,
  parameter logic [15:0] MEM_TIMEOUT     = 16'd64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_UsesRt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic        BranchTaken,
  input  logic        MemBusy,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        PipeHold,
  output logic        MemTimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [15:0] wdog;
  logic        hazard;

  assign hazard = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                  ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                   (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  // Mealy outputs; priority is memory hold, then branch flush, then load-use stall.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    PipeHold     = 1'b0;
    if (!RST_N) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (MemBusy) begin
      PipeHold    = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if ((state == LDSTALL) || hazard) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (!MemBusy) begin
      if (BranchTaken) begin
        state <= RUN;
        cnt   <= 2'd0;
      end else if (state == LDSTALL) begin
        if (cnt == 2'd1) begin
          state <= RUN;
          cnt   <= 2'd0;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end else if (hazard && (LOAD_USE_STALLS > 1)) begin
        state <= LDSTALL;
        cnt   <= 2'(LOAD_USE_STALLS - 1);
      end
    end
  end

  // Watchdog saturates so a stuck memory cannot wrap it back below the threshold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdog       <= 16'd0;
      MemTimeout <= 1'b0;
    end else if (MemBusy) begin
      if (wdog != MEM_TIMEOUT) begin
        wdog <= wdog + 16'd1;
        if ((wdog + 16'd1) == MEM_TIMEOUT) MemTimeout <= 1'b1;
      end
    end else begin
      wdog <= 16'd0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (ID_EX_Bubble) StallCount <= StallCount + 32'd1;
      if (!MemBusy && BranchTaken) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a reference model
module tb_hazard_ctrl;
  localparam int          LUS = 2;
  localparam logic [15:0] MT  = 16'd2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] IF_ID_RegisterRs = 5'd0;
  logic [4:0] IF_ID_RegisterRt = 5'd0;
  logic       IF_ID_UsesRt = 1'b0;
  logic       ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_RegisterRt = 5'd0;
  logic       BranchTaken = 1'b0;
  logic       MemBusy = 1'b0;
  logic       PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
  logic       ID_EX_Flush, EX_MEM_Flush, PipeHold, MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int checks = 0;
  int errors = 0;

  int          stall_left = 0;
  int          busy_len = 0;
  logic        tmo = 1'b0;
  logic [31:0] exp_stalls = 32'd0;
  logic [31:0] exp_flushes = 32'd0;

  hazard_ctrl #(.LOAD_USE_STALLS(LUS), .MEM_TIMEOUT(MT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_UsesRt(IF_ID_UsesRt), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_RegisterRt(ID_EX_RegisterRt), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .PipeHold(PipeHold), .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic is_hazard();
    return ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
           ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
            (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
  endfunction

  // {PCWrite, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PipeHold, MemTimeout}
  function automatic logic [7:0] model_out();
    if (!RST_N)                         return 8'b00_1_111_0_0;
    if (MemBusy)                        return {7'b00_0_000_1, tmo};
    if (BranchTaken)                    return {7'b11_0_111_0, tmo};
    if (stall_left > 0 || is_hazard())  return {7'b00_1_000_0, tmo};
    return {7'b11_0_000_0, tmo};
  endfunction

  function automatic logic [7:0] obs();
    return {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
            ID_EX_Flush, EX_MEM_Flush, PipeHold, MemTimeout};
  endfunction

  task automatic check(input string tag);
    logic [7:0] o, e;
    o = obs();
    e = model_out();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    assert (StallCount === exp_stalls && FlushCount === exp_flushes) else begin
      errors++;
      $error("FAIL %s_perf observed=%0d/%0d expected=%0d/%0d", tag,
             StallCount, FlushCount, exp_stalls, exp_flushes);
    end
`endif
  endtask

  task automatic expect_lit(input string tag, input logic [7:0] lit);
    logic [7:0] o;
    o = obs();
    checks++;
    assert (o === lit) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, lit);
    end
  endtask

  task automatic model_edge();
    logic [7:0] e;
    e = model_out();
    if (e[5]) exp_stalls++;
    if (!MemBusy && BranchTaken) exp_flushes++;
    if (MemBusy) begin
      if (busy_len < int'(MT)) busy_len++;
      if (busy_len == int'(MT)) tmo = 1'b1;
    end else begin
      busy_len = 0;
      if (BranchTaken)         stall_left = 0;
      else if (stall_left > 0) stall_left--;
      else if (is_hazard())    stall_left = LUS - 1;
    end
  endtask

  task automatic drive(input logic busy, input logic br, input logic mr, input logic [4:0] idrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ut);
    MemBusy = busy; BranchTaken = br; ID_EX_MemRead = mr; ID_EX_RegisterRt = idrt;
    IF_ID_RegisterRs = rs; IF_ID_RegisterRt = rt; IF_ID_UsesRt = ut;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag, input logic busy, input logic br, input logic mr,
                      input logic [4:0] idrt, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [7:0] lit);
    drive(busy, br, mr, idrt, rs, rt, ut);
    check(tag);
    expect_lit({tag, "_lit"}, lit);
    tick();
  endtask

  task automatic do_reset(input string tag);
    MemBusy = 0; BranchTaken = 0; ID_EX_MemRead = 0; ID_EX_RegisterRt = 0;
    IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0; IF_ID_UsesRt = 0;
    RST_N = 1'b0;
    stall_left = 0; busy_len = 0; tmo = 1'b0; exp_stalls = 0; exp_flushes = 0;
    #1;
    check(tag);
    expect_lit({tag, "_lit"}, 8'h3C);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    do_reset("reset");

    // Two-cycle load-use stall, then release
    step("t2_idle",  0, 0, 1, 5'd8, 5'd3, 5'd4, 1, 8'hC0);
    step("t2_haz",   0, 0, 1, 5'd8, 5'd8, 5'd4, 0, 8'h20);
    step("t2_ldst",  0, 0, 1, 5'd8, 5'd8, 5'd4, 0, 8'h20);
    step("t2_done",  0, 0, 0, 5'd8, 5'd8, 5'd4, 0, 8'hC0);

    // Non-hazards: Rt zero, Rt match without UsesRt; then Rt match with UsesRt
    step("t3_rt0",   0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 8'hC0);
    step("t3_noutr", 0, 0, 1, 5'd8, 5'd3, 5'd8, 0, 8'hC0);
    step("t3_usesrt",0, 0, 1, 5'd8, 5'd3, 5'd8, 1, 8'h20);
    step("t3_ldst",  0, 0, 0, 5'd8, 5'd3, 5'd8, 1, 8'h20);
    step("t3_done",  0, 0, 0, 5'd8, 5'd3, 5'd8, 1, 8'hC0);

    // Branch aborts the stall in its first LDSTALL cycle
    step("t4_haz",   0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 8'h20);
    step("t4_flush", 0, 1, 0, 5'd9, 5'd9, 5'd0, 0, 8'hDC);
    step("t4_run",   0, 0, 0, 5'd9, 5'd9, 5'd0, 0, 8'hC0);

    // Memory busy for three cycles trips the watchdog on the second edge
    step("t5_busy1", 1, 1, 1, 5'd9, 5'd9, 5'd0, 0, 8'h02);
    step("t5_busy2", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 8'h02);
    step("t5_busy3", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 8'h03);
    step("t5_after", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 8'hC1);

    // Reset asserted mid-stall takes effect immediately
    step("t1_haz",   0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 8'h21);
    do_reset("t1_rst");
    step("t1_run",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 8'hC0);

    step("t6_haz",   0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 8'h20);
    step("t6_ldst",  0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 8'h20);
    step("t6_idle",  0, 0, 0, 5'd8, 5'd8, 5'd0, 0, 8'hC0);
    step("t6_br",    0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 8'hDC);
    step("t6_end",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 8'hC0);
`ifdef HAZARD_PERF_EN
    checks++;
    assert (StallCount === 32'd2 && FlushCount === 32'd1) else begin
      errors++;
      $error("FAIL t6_perf observed=%0d/%0d expected=2/1", StallCount, FlushCount);
    end
`endif

    for (int r = 0; r < 4; r++) begin
      do_reset("rnd_reset");
      for (int i = 0; i < 150; i++) begin
        drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom));
        check("rnd");
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
